mdu: RTL

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers, runs fixed-latency mult/div operations, and services mthi/mtlo/mfhi/mflo. Its `start` and `busy` outputs feed the hazard/stall unit, which freezes D whenever an HI/LO instruction is decoded while `start | busy` is high. A pending exception/interrupt (`req`) suppresses launches so that flushed instructions never modify HI/LO.

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_if.sv | 25 ++
 rtl/mdu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the HI/LO hazard decode.
// MDU_MADD_EN enables the madd/maddu/msub/msubu op codes.
package mdu_pkg;

   localparam int unsigned OP_W            = 4;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [OP_W-1:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_compute(input logic [OP_W-1:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> multiply/divide unit signal bundle.
interface mdu_if;
   import mdu_pkg::*;

   logic            start;
   logic [OP_W-1:0] md_op;
   logic            req;
   logic [31:0]     rs_data;
   logic [31:0]     rt_data;
   logic            busy;
   logic [31:0]     hi;
   logic [31:0]     lo;
   logic [31:0]     md_rd;

   modport master (
      output start, md_op, req, rs_data, rt_data,
      input  busy, hi, lo, md_rd
   );

   modport slave (
      input  start, md_op, req, rs_data, rt_data,
      output busy, hi, lo, md_rd
   );

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, runs fixed-latency mult/div, services mfhi/mflo/mthi/mtlo.
// Define MDU_MADD_EN to build the madd/msub accumulation datapath.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   mdu_state_e     state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [63:0]    pend_q, pend_d;
   logic [31:0]    hi_q, hi_d;
   logic [31:0]    lo_q, lo_d;

   logic signed [63:0] rs_s, rt_s, prod_s;
   logic [63:0]        prod_u;
   logic               div_ovf;
   logic [31:0]        div_b;
   logic signed [31:0] quo_s, rem_s;
   logic [63:0]        res;
   logic [CW-1:0]      launch_cnt;

   // Divisor is forced to 1 for /0 and MIN/-1 so the arithmetic never traps; those cases pick fixed results.
   always_comb begin
      rs_s       = $signed({{32{bus.rs_data[31]}}, bus.rs_data});
      rt_s       = $signed({{32{bus.rt_data[31]}}, bus.rt_data});
      prod_s     = rs_s * rt_s;
      prod_u     = {32'h0, bus.rs_data} * {32'h0, bus.rt_data};
      div_ovf    = (bus.rs_data == 32'h8000_0000) && (bus.rt_data == 32'hFFFF_FFFF);
      div_b      = ((bus.rt_data == '0) || div_ovf) ? 32'd1 : bus.rt_data;
      quo_s      = $signed(bus.rs_data) / $signed(div_b);
      rem_s      = $signed(bus.rs_data) % $signed(div_b);
      res        = {hi_q, lo_q};
      launch_cnt = CW'(MULT_CYCLES);
      case (bus.md_op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV: begin
            launch_cnt = CW'(DIV_CYCLES);
            if (div_ovf)                  res = {32'h0, 32'h8000_0000};
            else if (bus.rt_data != '0)   res = {rem_s, quo_s};
         end
         OP_DIVU: begin
            launch_cnt = CW'(DIV_CYCLES);
            if (bus.rt_data != '0) res = {bus.rs_data % div_b, bus.rs_data / div_b};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  res = {hi_q, lo_q} + prod_s;
         OP_MADDU: res = {hi_q, lo_q} + prod_u;
         OP_MSUB:  res = {hi_q, lo_q} - prod_s;
         OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (!bus.req) begin
               if (bus.start && is_compute(bus.md_op)) begin
                  state_d = S_RUN;
                  count_d = launch_cnt;
                  pend_d  = res;
               end else if (bus.md_op == OP_MTHI) begin
                  hi_d = bus.rs_data;
               end else if (bus.md_op == OP_MTLO) begin
                  lo_d = bus.rs_data;
               end
            end
         end
         S_RUN: begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = S_IDLE;
               hi_d    = pend_q[63:32];
               lo_d    = pend_q[31:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q == S_RUN);
      bus.hi   = hi_q;
      bus.lo   = lo_q;
      case (bus.md_op)
         OP_MFHI: bus.md_rd = hi_q;
         OP_MFLO: bus.md_rd = lo_q;
         default: bus.md_rd = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule
